regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 127 ++++++++++++
 tb/tb_regfile_sb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with per-entry busy scoreboard, sequential clear after reset/clr,
// and optional same-cycle write forwarding to both read ports.
module regfile_sb #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          ready,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          iss_v,
    input  logic [AW-1:0] iss_a,
    output logic          busy1,
    output logic          busy2,
    output logic          dbg_state
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy_q;

    logic run;
    logic wr_en;
    logic iss_en;

    assign run       = (state_q == RUN);
    assign ready     = run;
    assign dbg_state = state_q;

    // Entry 0 is excluded from writes and issues when it is hardwired to zero.
    assign wr_en  = run && we && !(ZERO_R0 && (wa == '0));
    assign iss_en = run && iss_v && !(ZERO_R0 && (iss_a == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == {AW{1'b1}}) state_d = RUN;
            end
            RUN: begin
                if (clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) mem[cnt_q] <= '0;
            else if (wr_en) mem[wa] <= wd;
        end
    end

    // Issue is applied after the write-clear so a same-address issue keeps the entry busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                busy_q[cnt_q] <= 1'b0;
            end else begin
                if (wr_en)  busy_q[wa]    <= 1'b0;
                if (iss_en) busy_q[iss_a] <= 1'b1;
            end
        end
    end

    function automatic logic [DW-1:0] read_data(input logic [AW-1:0] ra);
        logic [DW-1:0] d;
        if (!run || (ZERO_R0 && (ra == '0)))   d = '0;
        else if (BYPASS && wr_en && (wa == ra)) d = wd;
        else                                    d = mem[ra];
        return d;
    endfunction

    function automatic logic read_busy(input logic [AW-1:0] ra);
        logic b;
        if (!run || (ZERO_R0 && (ra == '0)))
            b = 1'b0;
        else if (BYPASS && wr_en && (wa == ra) && !(iss_en && (iss_a == ra)))
            b = 1'b0;
        else
            b = busy_q[ra];
        return b;
    endfunction

    always_comb begin
        rd1   = read_data(ra1);
        rd2   = read_data(ra2);
        busy1 = read_busy(ra1);
        busy2 = read_busy(ra2);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb at default parameters; expected values are queued
// when stimulus is driven and popped at each check.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, clr, ready, we, iss_v, busy1, busy2, dbg_state;
    logic [AW-1:0] wa, ra1, ra2, iss_a;
    logic [DW-1:0] wd, rd1, rd2;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [32];
    int            total = 0;
    int            passed = 0;
    int            n;

    regfile_sb dut (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready),
        .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .iss_v(iss_v), .iss_a(iss_a),
        .busy1(busy1), .busy2(busy2), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs);
        logic [DW-1:0] e;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) passed++;
            else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic idle();
        we = 1'b0; iss_v = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wd = '0;
        ra1 = '0; ra2 = '0; iss_v = 1'b0; iss_a = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset: ready low for exactly 32 cycles, writes/issues ignored meanwhile.
        tick();
        rst = 1'b0;
        we = 1'b1; wa = 5'd4; wd = 32'h1111_2222; iss_v = 1'b1; iss_a = 5'd4; ra1 = 5'd4;
        #1;
        exp_q.push_back(0); chk("ready_in_init", ready);
        exp_q.push_back(0); chk("rd1_in_init", rd1);
        exp_q.push_back(0); chk("busy1_in_init", busy1);
        exp_q.push_back(32); wait_ready(n); chk("reset_init_cycles", n);
        idle();
        #1;
        for (int i = 0; i < 32; i++) begin
            ra1 = AW'(i); ra2 = AW'(31 - i);
            #1;
            exp_q.push_back(0); chk("rd1_after_reset", rd1);
            exp_q.push_back(0); chk("busy2_after_reset", busy2);
        end

        // Write with same-cycle bypass on both ports, then stored value.
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd5;
        #1;
        exp_q.push_back(32'hDEAD_BEEF); chk("rd1_bypass", rd1);
        exp_q.push_back(32'hDEAD_BEEF); chk("rd2_bypass", rd2);
        tick(); model[5] = 32'hDEAD_BEEF; we = 1'b0;
        #1;
        exp_q.push_back(32'hDEAD_BEEF); chk("rd1_stored", rd1);

        // Entry 0 ignores writes and issues.
        we = 1'b1; wa = 5'd0; wd = 32'h1234_5678; iss_v = 1'b1; iss_a = 5'd0; ra1 = 5'd0;
        #1;
        exp_q.push_back(0); chk("r0_rd_same", rd1);
        exp_q.push_back(0); chk("r0_busy_same", busy1);
        tick(); idle();
        #1;
        exp_q.push_back(0); chk("r0_rd_later", rd1);
        exp_q.push_back(0); chk("r0_busy_later", busy1);

        // Scoreboard set/hold/clear on entry 7.
        ra1 = 5'd7; iss_v = 1'b1; iss_a = 5'd7;
        #1;
        exp_q.push_back(0); chk("busy_before_issue", busy1);
        tick(); idle();
        #1;
        exp_q.push_back(1); chk("busy_after_issue", busy1);
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0077; iss_v = 1'b1; iss_a = 5'd7;
        #1;
        exp_q.push_back(1); chk("busy_we_and_issue", busy1);
        tick(); model[7] = 32'h0000_0077; idle();
        #1;
        exp_q.push_back(1); chk("busy_held", busy1);
        exp_q.push_back(32'h0000_0077); chk("rd_written_with_issue", rd1);
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0777;
        #1;
        exp_q.push_back(0); chk("busy_we_bypass", busy1);
        tick(); model[7] = 32'h0000_0777; idle();
        #1;
        exp_q.push_back(0); chk("busy_cleared", busy1);

        // Random writes then read back on both ports against the model.
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wa = AW'($urandom_range(1, 31)); wd = $urandom;
            tick(); model[wa] = wd;
        end
        idle();
        for (int i = 1; i < 32; i += 3) begin
            ra1 = AW'(i); ra2 = AW'(i);
            #1;
            exp_q.push_back(model[i]); chk("rand_rd1", rd1);
            exp_q.push_back(model[i]); chk("rand_rd2", rd2);
        end

        // clr mid-run: entry 3 and a pending busy bit are wiped.
        iss_v = 1'b1; iss_a = 5'd12; we = 1'b1; wa = 5'd3; wd = 32'h0000_00A5;
        tick(); idle(); ra1 = 5'd3; ra2 = 5'd12;
        #1;
        exp_q.push_back(32'h0000_00A5); chk("rd3_before_clr", rd1);
        exp_q.push_back(1); chk("busy12_before_clr", busy2);
        clr = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h0000_0099;
        tick(); clr = 1'b0;
        we = 1'b1; wa = 5'd3; wd = 32'h0000_00FF;
        #1;
        exp_q.push_back(0); chk("ready_after_clr", ready);
        exp_q.push_back(32); wait_ready(n); chk("clr_init_cycles", n);
        idle();
        #1;
        exp_q.push_back(0); chk("rd3_after_clr", rd1);
        exp_q.push_back(0); chk("busy12_after_clr", busy2);
        ra2 = 5'd9;
        #1;
        exp_q.push_back(0); chk("rd9_after_clr", rd2);

        // rst mid-INIT at cnt=10 restarts the full clear.
        we = 1'b1; wa = 5'd20; wd = 32'h0000_2020;
        tick(); idle(); clr = 1'b1;
        tick(); clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1; clr = 1'b1; we = 1'b1; wa = 5'd21; wd = 32'hFFFF_FFFF;
        tick(); rst = 1'b0; idle();
        #1;
        exp_q.push_back(32); wait_ready(n); chk("rst_mid_init_cycles", n);
        ra1 = 5'd20; ra2 = 5'd21;
        #1;
        exp_q.push_back(0); chk("rd20_after_rst", rd1);
        exp_q.push_back(0); chk("rd21_after_rst", rd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
